layer_pingpong_bank_scheduler: RTL

Double-buffer scheduler for the feature memory between two adjacent CNN layers. It owns two identical feature-RAM banks. The former layer fills one bank while the next layer drains the other, so the two layers overlap instead of serialising on a single shared RAM. The block sits between the former layer's write port, the next layer's read port and the two bank RAMs. It also generates the enable/reset sequencing for both layers.

---
 rtl/layer_pingpong_bank_scheduler_pkg.sv | 15 +
 rtl/layer_pingpong_bank_scheduler_port_mux.sv | 35 +++
 rtl/layer_pingpong_bank_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/layer_pingpong_bank_scheduler_pkg.sv
// Shared definitions for the layer ping-pong bank scheduler: bank-state encoding and defaults.
package layer_pingpong_bank_scheduler_pkg;

    localparam int STATE_W        = 2;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef logic [STATE_W-1:0] bank_state_t;

    // Bit 1 set means the bank holds a complete frame (FULL or DRAINING).
    localparam bank_state_t EMPTY    = 2'd0;
    localparam bank_state_t FILLING  = 2'd1;
    localparam bank_state_t FULL     = 2'd2;
    localparam bank_state_t DRAINING = 2'd3;

endpackage

// File: rtl/layer_pingpong_bank_scheduler_port_mux.sv
// Per-bank port steering: routes the former layer's write port or the next layer's read port
// onto one bank according to that bank's registered state.
module layer_bank_port_mux
    import layer_pingpong_bank_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  bank_state_t           i_state,
    input  logic                  i_wren_former,
    input  logic [ADDR_WIDTH-1:0] i_addr_former,
    input  logic                  i_rden_next,
    input  logic [ADDR_WIDTH-1:0] i_addr_next,
    output logic                  o_wren,
    output logic                  o_rden,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    always_comb begin
        o_wren = 1'b0;
        o_rden = 1'b0;
        o_addr = '0;
        case (i_state)
            FILLING: begin
                o_wren = i_wren_former;
                o_addr = i_addr_former;
            end
            DRAINING: begin
                o_rden = i_rden_next;
                o_addr = i_addr_next;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/layer_pingpong_bank_scheduler.sv
// Double-buffer scheduler between two CNN layers: the former layer fills one bank while the
// next layer drains the other; also sequences both layers' enable/reset.
module layer_pingpong_bank_scheduler
    import layer_pingpong_bank_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  downstream_free,
    output logic                  former_enable,
    output logic                  former_reset,
    input  logic                  former_done,
    output logic                  next_enable,
    output logic                  next_reset,
    input  logic                  next_done,
    input  logic                  wren_former,
    input  logic [ADDR_WIDTH-1:0] addr_former,
    input  logic                  rden_next,
    input  logic [ADDR_WIDTH-1:0] addr_next,
    output logic                  bank0_wren,
    output logic                  bank0_rden,
    output logic [ADDR_WIDTH-1:0] bank0_addr,
    output logic                  bank1_wren,
    output logic                  bank1_rden,
    output logic [ADDR_WIDTH-1:0] bank1_addr,
    output logic                  rd_bank_sel,
    output logic [1:0]            bank_full,
    output logic [CNT_WIDTH-1:0]  frames_done
);

    bank_state_t          r_state [2];
    bank_state_t          w_state_nxt [2];
    logic                 r_wr_ptr, r_rd_ptr;
    logic                 w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic                 r_fdone_d, r_ndone_d;
    logic                 r_fdone_rise, r_ndone_rise;
    logic                 r_former_reset, r_next_reset;
    logic [CNT_WIDTH-1:0] r_frames;

    logic w_filling, w_draining;
    logic w_fill_idx, w_drain_idx;
    logic w_fill_start, w_fill_end, w_drain_start, w_drain_end;

    assign w_filling   = (r_state[0] == FILLING)  || (r_state[1] == FILLING);
    assign w_draining  = (r_state[0] == DRAINING) || (r_state[1] == DRAINING);
    assign w_fill_idx  = (r_state[1] == FILLING);
    assign w_drain_idx = (r_state[1] == DRAINING) ? 1'b1 :
                         (r_state[0] == DRAINING) ? 1'b0 : r_rd_ptr;

    // Starts look only at registered state, so a bank freed this cycle restarts one cycle later.
    assign w_fill_start  = enable && (r_state[r_wr_ptr] == EMPTY) && !w_filling;
    assign w_fill_end    = r_fdone_rise && w_filling;
    assign w_drain_start = enable && downstream_free && (r_state[r_rd_ptr] == FULL) && !w_draining;
    assign w_drain_end   = r_ndone_rise && w_draining;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        for (int i = 0; i < 2; i++) begin
            if (w_fill_end && (w_fill_idx == 1'(i)))     w_state_nxt[i] = FULL;
            if (w_drain_end && (w_drain_idx == 1'(i)))   w_state_nxt[i] = EMPTY;
            if (w_fill_start && (r_wr_ptr == 1'(i)))     w_state_nxt[i] = FILLING;
            if (w_drain_start && (r_rd_ptr == 1'(i)))    w_state_nxt[i] = DRAINING;
        end
        if (w_fill_end)  w_wr_ptr_nxt = ~r_wr_ptr;
        if (w_drain_end) w_rd_ptr_nxt = ~r_rd_ptr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state[0]     <= EMPTY;
            r_state[1]     <= EMPTY;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fdone_d      <= 1'b0;
            r_ndone_d      <= 1'b0;
            r_fdone_rise   <= 1'b0;
            r_ndone_rise   <= 1'b0;
            r_former_reset <= 1'b0;
            r_next_reset   <= 1'b0;
            r_frames       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_fdone_d      <= former_done;
            r_ndone_d      <= next_done;
            r_fdone_rise   <= former_done && !r_fdone_d;
            r_ndone_rise   <= next_done && !r_ndone_d;
            r_former_reset <= w_fill_start;
            r_next_reset   <= w_drain_start;
            if (w_drain_end) r_frames <= r_frames + 1'b1;
        end
    end

    assign former_enable = w_filling;
    assign former_reset  = r_former_reset;
    assign next_enable   = w_draining;
    assign next_reset    = r_next_reset;
    assign rd_bank_sel   = w_drain_idx;
    assign bank_full     = {r_state[1][1], r_state[0][1]};
    assign frames_done   = r_frames;

    layer_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .i_state       (r_state[0]),
        .i_wren_former (wren_former),
        .i_addr_former (addr_former),
        .i_rden_next   (rden_next),
        .i_addr_next   (addr_next),
        .o_wren        (bank0_wren),
        .o_rden        (bank0_rden),
        .o_addr        (bank0_addr)
    );

    layer_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .i_state       (r_state[1]),
        .i_wren_former (wren_former),
        .i_addr_former (addr_former),
        .i_rden_next   (rden_next),
        .i_addr_next   (addr_next),
        .o_wren        (bank1_wren),
        .o_rden        (bank1_rden),
        .o_addr        (bank1_addr)
    );

endmodule
